// File: rtl/midi_uart_rx_if.sv
// rtl/midi_uart_rx_if.sv - MIDI serial line in, received bytes and note events out
interface midi_uart_rx_if;
    logic       midi_rx;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic       framing_error;
    logic       note_valid;
    logic       note_on;
    logic [3:0] note_channel;
    logic [6:0] note_num;
    logic [6:0] note_vel;

    modport master (
        input  midi_rx,
        output midi_data, midi_valid, framing_error,
        output note_valid, note_on, note_channel, note_num, note_vel
    );

    modport slave (
        output midi_rx,
        input  midi_data, midi_valid, framing_error,
        input  note_valid, note_on, note_channel, note_num, note_vel
    );
endinterface

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI UART receiver with Note On/Off parser and running status
module midi_uart_rx #(
    parameter int CLKS_PER_BIT = 1600
) (
    input  logic           clk,
    input  logic           rst_n,
    midi_uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    logic [7:0]    status_q, status_d;
    logic          has_status_q, has_status_d;
    logic          data_cnt_q, data_cnt_d;
    logic [6:0]    first_q, first_d;
    logic          note_valid_q, note_valid_d;
    logic          note_on_q, note_on_d;
    logic [3:0]    note_channel_q, note_channel_d;
    logic [6:0]    note_num_q, note_num_d;
    logic [6:0]    note_vel_q, note_vel_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-start-bit sample: a high line here means the edge was a glitch
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status_d       = status_q;
        has_status_d   = has_status_q;
        data_cnt_d     = data_cnt_q;
        first_d        = first_q;
        note_valid_d   = 1'b0;
        note_on_d      = note_on_q;
        note_channel_d = note_channel_q;
        note_num_d     = note_num_q;
        note_vel_d     = note_vel_q;
        if (valid_q) begin
            if (data_q[7:3] == 5'b11111) begin
                // realtime bytes are transparent to the message in progress
            end else if (data_q[7:4] == 4'hF) begin
                has_status_d = 1'b0;
            end else if (data_q[7]) begin
                status_d     = data_q;
                has_status_d = 1'b1;
                data_cnt_d   = 1'b0;
            end else if (has_status_q) begin
                if (status_q[7:5] == 3'b110) begin
                    data_cnt_d = 1'b0;
                end else if (!data_cnt_q) begin
                    first_d    = data_q[6:0];
                    data_cnt_d = 1'b1;
                end else begin
                    data_cnt_d = 1'b0;
                    if (status_q[7:5] == 3'b100) begin
                        note_valid_d   = 1'b1;
                        note_on_d      = status_q[4] && (data_q[6:0] != 7'd0);
                        note_channel_d = status_q[3:0];
                        note_num_d     = first_q;
                        note_vel_d     = data_q[6:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            ferr_q         <= 1'b0;
            status_q       <= '0;
            has_status_q   <= 1'b0;
            data_cnt_q     <= 1'b0;
            first_q        <= '0;
            note_valid_q   <= 1'b0;
            note_on_q      <= 1'b0;
            note_channel_q <= '0;
            note_num_q     <= '0;
            note_vel_q     <= '0;
        end else begin
            rx_meta_q      <= bus.midi_rx;
            rx_sync_q      <= rx_meta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            ferr_q         <= ferr_d;
            status_q       <= status_d;
            has_status_q   <= has_status_d;
            data_cnt_q     <= data_cnt_d;
            first_q        <= first_d;
            note_valid_q   <= note_valid_d;
            note_on_q      <= note_on_d;
            note_channel_q <= note_channel_d;
            note_num_q     <= note_num_d;
            note_vel_q     <= note_vel_d;
        end
    end

    assign bus.midi_data     = data_q;
    assign bus.midi_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.note_valid    = note_valid_q;
    assign bus.note_on       = note_on_q;
    assign bus.note_channel  = note_channel_q;
    assign bus.note_num      = note_num_q;
    assign bus.note_vel      = note_vel_q;
endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - directed and randomized byte streams against a message-level MIDI model
module tb_midi_uart_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   last_mv_cyc = -10;
    int   fe_cnt = 0;

    midi_uart_rx_if bus ();

    midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  got_bytes[$], exp_bytes[$];
    logic [18:0] got_notes[$], exp_notes[$];

    bit          m_has = 1'b0;
    logic [7:0]  m_status = 8'h00;
    logic [6:0]  m_pend[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.midi_valid === 1'b1) begin
            got_bytes.push_back(bus.midi_data);
            last_mv_cyc = cyc;
            chk("mv_latency_in_range", ((cyc - t_start) >= 153 && (cyc - t_start) <= 157), 1);
        end
        if (bus.note_valid === 1'b1) begin
            got_notes.push_back({bus.note_on, bus.note_channel, bus.note_num, bus.note_vel});
            chk("note_after_mv", cyc - last_mv_cyc, 1);
        end
        if (bus.framing_error === 1'b1) fe_cnt++;
    end

    function automatic int msg_len(input logic [7:0] st);
        return (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_has = 1'b0; m_pend.delete(); return; end
        if (b >= 8'h80) begin m_has = 1'b1; m_status = b; m_pend.delete(); return; end
        if (!m_has) return;
        m_pend.push_back(b[6:0]);
        if (m_pend.size() == msg_len(m_status)) begin
            if (m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9)
                exp_notes.push_back({(m_status[7:4] == 4'h9) && (m_pend[1] != 0),
                                     m_status[3:0], m_pend[0], m_pend[1]});
            m_pend.delete();
        end
    endfunction

    task automatic drive(input logic v, input int n);
        bus.midi_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        t_start = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    task automatic send_model(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b1);
    endtask

    task automatic check_queues(input string tag, input int exp_fe);
        drive(1'b1, 4);
        chk({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            chk({tag, "_byte"}, got_bytes[i], exp_bytes[i]);
        chk({tag, "_nnotes"}, got_notes.size(), exp_notes.size());
        for (int i = 0; i < got_notes.size() && i < exp_notes.size(); i++)
            chk({tag, "_note"}, got_notes[i], exp_notes[i]);
        chk({tag, "_ferr"}, fe_cnt, exp_fe);
        got_bytes.delete(); exp_bytes.delete();
        got_notes.delete(); exp_notes.delete();
        fe_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"},  bus.midi_data, 0);
        chk({tag, "_valid"}, bus.midi_valid, 0);
        chk({tag, "_ferr"},  bus.framing_error, 0);
        chk({tag, "_nvalid"}, bus.note_valid, 0);
        chk({tag, "_non"},   bus.note_on, 0);
        chk({tag, "_nch"},   bus.note_channel, 0);
        chk({tag, "_nnum"},  bus.note_num, 0);
        chk({tag, "_nvel"},  bus.note_vel, 0);
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] b;
        int r;
        bus.midi_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        drive(1'b1, 2 * CPB);

        send_model(8'h90); send_model(8'h3C); send_model(8'h64);
        check_queues("note_on", 0);
        chk("s1_fields", {bus.note_on, bus.note_channel, bus.note_num, bus.note_vel},
            {1'b1, 4'd0, 7'd60, 7'd100});

        send_model(8'h93); send_model(8'h40); send_model(8'h7F);
        send_model(8'h40); send_model(8'h00);
        check_queues("running", 0);
        chk("s2_fields_hold", {bus.note_on, bus.note_channel, bus.note_num, bus.note_vel},
            {1'b0, 4'd3, 7'd64, 7'd0});

        send_model(8'h80); send_model(8'h3C); send_model(8'hF8); send_model(8'h40);
        send_model(8'hF0); send_model(8'h3C); send_model(8'h40);
        check_queues("realtime", 0);

        prev = bus.midi_data;
        send_byte(8'h55, 1'b0);
        drive(1'b1, 2 * CPB);
        chk("frame_data_kept", bus.midi_data, prev);
        send_model(8'hAA);
        check_queues("framing", 1);

        drive(1'b0, 4);
        drive(1'b1, 3 * CPB);
        check_queues("glitch", 0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            if (r < 2)       b = 8'h80 | (8'($urandom_range(0, 1)) << 4) | 8'($urandom_range(0, 15));
            else if (r == 2) b = 8'h80 + 8'($urandom_range(0, 6)) * 8'h10 + 8'($urandom_range(0, 15));
            else if (r == 3) b = 8'hF0 + 8'($urandom_range(0, 15));
            else if (r == 4) b = 8'h00;
            else             b = 8'($urandom_range(0, 127));
            send_model(b);
        end
        check_queues("random", 0);

        send_model(8'h90);
        check_queues("pre_reset", 0);
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(1'b0, CPB);
        drive(1'b1, CPB / 2);
        rst_n = 1'b0;
        #2;
        check_all_zero("midreset");
        drive(1'b1, 4);
        rst_n = 1'b1;
        drive(1'b1, 3 * CPB);
        m_has = 1'b0;
        m_pend.delete();
        send_model(8'h12); send_model(8'h3C); send_model(8'h40);
        check_queues("after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
